conv2d_row_acc: RTL and testbench

CONV2D_ROW_ACC -- requirements
Module: conv2d_row_acc

---
 rtl/conv2d_pkg.sv | 22 ++
 rtl/conv2d_out_fifo.sv | 77 +++++++
 rtl/conv2d_row_acc.sv | 158 +++++++++++++++
 tb/tb_conv2d_row_acc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_pkg
// Description : Shared definitions for the conv2d row accumulator, PE and
//               feeder: default widths and the accumulator FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package conv2d_pkg;

    localparam int DEF_DWIDTH     = 32;
    localparam int DEF_WT_DIM     = 3;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/conv2d_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_out_fifo
// Description : Synchronous FIFO for accumulator results. Supports push and
//               pop in the same cycle at any occupancy, including full.
//               Read data is 0 while empty.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_push, i_data - write request / data
//               i_pop          - read request (ignored when empty)
//               o_data         - head entry
//               o_full/o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_out_fifo
    import conv2d_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_cnt;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_cnt == c_FULL_CNT);
    assign o_empty = (r_cnt == '0);

    // A pop frees the head slot this cycle, so a full FIFO can still accept.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv2d_row_acc.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_row_acc
// Description : Sums the WT_DIM PE partial-sum words of each all-valid cycle,
//               registers the sum for one cycle and queues it in an output
//               FIFO. A frame produces fm_dim*fm_dim results; results that
//               find the FIFO full are dropped, still counted, and flagged
//               in the sticky overflow output.
// Macro       : CONV2D_ACC_RELU_EN - when defined, negative (signed) sums are
//               clamped to 0 before the FIFO write.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               start, fm_dim          - frame start pulse and side length
//               pe_data_i, pe_valid_i  - PE partial sums and per-PE valids
//               acc_data_o/valid/ready - result stream (FIFO head)
//               busy, done, overflow   - frame status
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_row_acc
    import conv2d_pkg::*;
#(
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int WT_DIM     = DEF_WT_DIM,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DWIDTH-1:0]        fm_dim,
    input  logic [WT_DIM*DWIDTH-1:0] pe_data_i,
    input  logic [WT_DIM-1:0]        pe_valid_i,
    output logic [DWIDTH-1:0]        acc_data_o,
    output logic                     acc_valid_o,
    input  logic                     acc_ready_i,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    acc_state_t          r_state;
    acc_state_t          w_next;
    logic [2*DWIDTH-1:0] r_target;
    logic [2*DWIDTH-1:0] r_count;
    logic [2*DWIDTH-1:0] w_count_inc;
    logic [DWIDTH-1:0]   w_sum;
    logic [DWIDTH-1:0]   r_pipe_data;
    logic [DWIDTH-1:0]   w_wr_data;
    logic                r_pipe_valid;
    logic                r_overflow;
    logic                w_start_acc;
    logic                w_accept;
    logic                w_last;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_drop;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_accept    = (r_state == ST_RUN) && (&pe_valid_i);
    assign w_count_inc = r_count + (2*DWIDTH)'(1);
    assign w_last      = w_accept && (w_count_inc == r_target);

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < WT_DIM; k++) begin
            w_sum = w_sum + pe_data_i[k*DWIDTH +: DWIDTH];
        end
    end

`ifdef CONV2D_ACC_RELU_EN
    assign w_wr_data = r_pipe_data[DWIDTH-1] ? '0 : r_pipe_data;
`else
    assign w_wr_data = r_pipe_data;
`endif

    assign acc_valid_o = !w_empty;
    assign w_pop       = acc_valid_o && acc_ready_i;
    assign w_drop      = r_pipe_valid && w_full && !w_pop;
    assign overflow    = r_overflow;

    conv2d_out_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pipe_valid),
        .i_data  (w_wr_data),
        .i_pop   (acc_ready_i),
        .o_data  (acc_data_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (fm_dim == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_pipe_valid && w_empty) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target     <= '0;
            r_count      <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_pipe_valid <= w_accept;
            if (w_accept) begin
                r_pipe_data <= w_sum;
            end
            if (w_start_acc) begin
                r_target   <= {{DWIDTH{1'b0}}, fm_dim} * {{DWIDTH{1'b0}}, fm_dim};
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (w_accept) begin
                r_count <= w_count_inc;
            end
            // A dropped result still counted above when it was accepted.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_row_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_row_acc
// Description : Self-checking bench for conv2d_row_acc. Expected results are
//               queued when an all-valid cycle is driven and compared when
//               the DUT hands a result to the consumer.
// Macro       : CONV2D_ACC_RELU_EN - selects the clamped expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_row_acc;

    localparam int DW = 32;
    localparam int WD = 3;
    localparam int FD = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DW-1:0]    fm_dim;
    logic [WD*DW-1:0] pe_data_i;
    logic [WD-1:0]    pe_valid_i;
    logic [DW-1:0]    acc_data_o;
    logic             acc_valid_o;
    logic             acc_ready_i;
    logic             busy;
    logic             done;
    logic             overflow;

    int            n_total = 0;
    int            n_bad   = 0;
    int            done_cnt = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    conv2d_row_acc #(
        .DWIDTH     (DW),
        .WT_DIM     (WD),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .fm_dim      (fm_dim),
        .pe_data_i   (pe_data_i),
        .pe_valid_i  (pe_valid_i),
        .acc_data_o  (acc_data_o),
        .acc_valid_o (acc_valid_o),
        .acc_ready_i (acc_ready_i),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] a, b, c);
        logic [DW-1:0] s;
        s = a + b + c;
`ifdef CONV2D_ACC_RELU_EN
        if (s[DW-1]) s = '0;
`endif
        return s;
    endfunction

    // Observe on the falling edge: a handshake seen here pops at the next rise.
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        if (acc_valid_o === 1'b1 && acc_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out_valid", acc_valid_o, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_val("acc_data", acc_data_o, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [DW-1:0] dim);
        start  = 1'b1;
        fm_dim = dim;
        tick();
        start  = 1'b0;
    endtask

    task automatic do_acc(input logic [DW-1:0] a, b, c, input bit keep);
        pe_data_i  = {c, b, a};
        pe_valid_i = '1;
        if (keep) exp_q.push_back(model(a, b, c));
        tick();
        pe_valid_i = '0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        rst         = 1'b1;
        start       = 1'b0;
        fm_dim      = '0;
        pe_data_i   = '0;
        pe_valid_i  = '0;
        acc_ready_i = 1'b0;
        repeat (3) tick();
        check_val("rst_busy",     busy,        1'b0);
        check_val("rst_done",     done,        1'b0);
        check_val("rst_overflow", overflow,    1'b0);
        check_val("rst_valid",    acc_valid_o, 1'b0);
        check_val("rst_data",     acc_data_o,  32'h0);
        rst = 1'b0;
        tick();

        // Basic 2x2 frame, consumer always ready.
        acc_ready_i = 1'b1;
        do_start(2);
        check_val("t1_busy_run", busy, 1'b1);
        for (int i = 0; i < 4; i++) do_acc(1, 2, 3, 1);
        d0 = done_cnt;
        wait_done("t1_done", 50);
        check_val("t1_busy_after_done", busy, 1'b0);
        repeat (2) tick();
        check_val("t1_done_single", done_cnt - d0, 1);
        check_val("t1_queue_empty", exp_q.size(), 0);

        // Partial valid cycles are ignored.
        do_start(1);
        for (int i = 0; i < 5; i++) begin
            pe_data_i  = {32'd3, 32'd2, 32'd1};
            pe_valid_i = 3'b011;
            tick();
        end
        pe_valid_i = '0;
        tick();
        check_val("t2_still_run", busy, 1'b1);
        check_val("t2_no_output", acc_valid_o, 1'b0);
        do_acc(1, 2, 3, 1);
        wait_done("t2_done", 50);
        check_val("t2_queue_empty", exp_q.size(), 0);

        // Stalled consumer: 8 stored, 9th dropped.
        acc_ready_i = 1'b0;
        do_start(3);
        for (int i = 0; i < 9; i++) do_acc(DW'(i), 10, 100, i < 8);
        repeat (3) tick();
        check_val("t3_overflow", overflow, 1'b1);
        check_val("t3_valid", acc_valid_o, 1'b1);
        d0 = done_cnt;
        repeat (10) tick();
        check_val("t3_wait_drain_busy", busy, 1'b1);
        check_val("t3_no_early_done", done_cnt - d0, 0);
        acc_ready_i = 1'b1;
        wait_done("t3_done", 100);
        check_val("t3_queue_empty", exp_q.size(), 0);
        check_val("t3_overflow_sticky", overflow, 1'b1);

        // Full FIFO with simultaneous push and pop: nothing lost.
        acc_ready_i = 1'b0;
        do_start(3);
        check_val("t4_overflow_cleared", overflow, 1'b0);
        for (int i = 0; i < 8; i++) do_acc(DW'(i), 20, 200, 1);
        tick();
        do_acc(8, 20, 200, 1);
        acc_ready_i = 1'b1;
        tick();
        check_val("t4_no_overflow", overflow, 1'b0);
        wait_done("t4_done", 100);
        check_val("t4_queue_empty", exp_q.size(), 0);
        check_val("t4_overflow_end", overflow, 1'b0);

        // Wrapping sum (and clamp when enabled).
        acc_ready_i = 1'b1;
        do_start(1);
        do_acc(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 1);
        wait_done("t5_done", 50);
        check_val("t5_queue_empty", exp_q.size(), 0);

        // Reset mid-RUN with entries queued.
        acc_ready_i = 1'b0;
        do_start(3);
        for (int i = 0; i < 3; i++) do_acc(DW'(i), 1, 1, 1);
        repeat (2) tick();
        check_val("t6_pre_rst_valid", acc_valid_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t6_valid_after_rst", acc_valid_o, 1'b0);
        check_val("t6_idle_after_rst", busy, 1'b0);
        check_val("t6_data_after_rst", acc_data_o, 32'h0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (5) tick();
        check_val("t6_no_done", done_cnt - d0, 0);
        check_val("t6_still_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
